// File: rtl/ram_loader_pkg.sv
// ram_loader_pkg: shared CPU constants (byte/address widths, RAM depth) and loader state encoding
package ram_loader_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;
  localparam int RAM_DEPTH = 2 ** ADDR_W_DEF;
  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_BYTE,
    S_WRITE,
    S_VERIFY,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;
endpackage

// File: rtl/ram_loader_if.sv
// ram_loader_if: loader bundle (byte stream in, RAM addr/bus/strobes out, bus readback in, status out); master = loader, slave = surroundings
interface ram_loader_if
  import ram_loader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);
  logic              load_start;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] ld_add;
  logic [DATA_W-1:0] ld_bus_out;
  logic              ld_bus_oe;
  logic [DATA_W-1:0] bus_in;
  logic              ld_ram_in;
  logic              ld_ram_out;
  logic              cpu_hold;
  logic              load_ok;
  logic              load_err;
  modport master (
    input  load_start, in_data, in_valid, bus_in,
    output in_ready, ld_add, ld_bus_out, ld_bus_oe, ld_ram_in, ld_ram_out, cpu_hold, load_ok, load_err
  );
  modport slave (
    output load_start, in_data, in_valid, bus_in,
    input  in_ready, ld_add, ld_bus_out, ld_bus_oe, ld_ram_in, ld_ram_out, cpu_hold, load_ok, load_err
  );
endinterface

// File: rtl/ram_loader_checksum.sv
// ram_loader_checksum: mod-2**W byte accumulator (clk, rst, clr, add, din -> sum)
module ram_loader_checksum #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         add,
  input  logic [W-1:0] din,
  output logic [W-1:0] sum
);
  logic [W-1:0] sum_q, sum_d;
  always_comb sum_d = clr ? '0 : add ? sum_q + din : sum_q;
  always_ff @(posedge clk) sum_q <= rst ? '0 : sum_d;
  assign sum = sum_q;
endmodule

// File: rtl/ram_loader.sv
// ram_loader: fills the 16x8 program RAM from a valid/ready byte stream, checksums a readback, holds the CPU off the bus (clk, rst, ld: ram_loader_if.master)
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter bit VERIFY = 1'b1
) (
  input  logic clk,
  input  logic rst,
  ram_loader_if.master ld
);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] byte_q, byte_d;
  logic [DATA_W-1:0] wr_sum, rd_sum;
  logic              clr, wr_add, rd_add, last, wr, ver;
  assign last = &cnt_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    byte_d  = byte_q;
    clr     = 1'b0;
    wr_add  = 1'b0;
    rd_add  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (ld.load_start) begin
        clr     = 1'b1;
        cnt_d   = '0;
        state_d = S_WAIT_BYTE;
      end
      S_WAIT_BYTE: if (ld.in_valid) begin
        byte_d  = ld.in_data;
        wr_add  = 1'b1;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = !last ? S_WAIT_BYTE : VERIFY ? S_VERIFY : S_DONE;
      end
      S_VERIFY: begin
        rd_add  = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        state_d = last ? S_CHECK : S_VERIFY;
      end
      S_CHECK: state_d = rd_sum == wr_sum ? S_DONE : S_ERR;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
    end
  end
  ram_loader_checksum #(.W(DATA_W)) u_wr_sum (
    .clk(clk), .rst(rst), .clr(clr), .add(wr_add), .din(ld.in_data), .sum(wr_sum)
  );
  ram_loader_checksum #(.W(DATA_W)) u_rd_sum (
    .clk(clk), .rst(rst), .clr(clr), .add(rd_add), .din(ld.bus_in), .sum(rd_sum)
  );
  assign wr            = state_q == S_WRITE;
  assign ver           = state_q == S_VERIFY;
  assign ld.in_ready   = state_q == S_WAIT_BYTE;
  assign ld.ld_ram_in  = wr;
  assign ld.ld_bus_oe  = wr;
  assign ld.ld_ram_out = ver;
  assign ld.ld_add     = wr || ver ? cnt_q : '0;
  assign ld.ld_bus_out = wr ? byte_q : '0;
  assign ld.cpu_hold   = !(state_q == S_IDLE || state_q == S_DONE);
  assign ld.load_ok    = state_q == S_DONE;
  assign ld.load_err   = state_q == S_ERR;
endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: directed checks of ram_loader with and without the readback verify pass
module tb_ram_loader;
  import ram_loader_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  ram_loader_if f1 ();
  ram_loader_if f0 ();
  ram_loader #(.VERIFY(1'b1)) u1 (.clk(clk), .rst(rst), .ld(f1.master));
  ram_loader #(.VERIFY(1'b0)) u0 (.clk(clk), .rst(rst), .ld(f0.master));
  logic [7:0] mem [16];
  logic [7:0] img [16];
  logic corrupt = 1'b0;
  always @(posedge clk)
    if (f1.ld_ram_in) mem[f1.ld_add] <= f1.ld_bus_out ^ {7'd0, corrupt && f1.ld_add == 4'd7};
  assign f1.bus_in = f1.ld_ram_out ? mem[f1.ld_add] : 8'h00;
  assign f0.bus_in = 8'h00;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  int exp_addr = 0, exp0 = 0, strobes = 0, w1 = 0, w0 = 0, viol = 0, ro0 = 0, c = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (f1.ld_ram_in) begin
      chk("wr_addr", 32'(f1.ld_add), 32'(exp_addr));
      chk("wr_data", 32'(f1.ld_bus_out), 32'(img[exp_addr]));
      exp_addr = (exp_addr + 1) % 16;
      strobes++;
      w1 = cyc;
    end
    if (f0.ld_ram_in) begin
      chk("wr0_addr", 32'(f0.ld_add), 32'(exp0));
      exp0 = (exp0 + 1) % 16;
      w0 = cyc;
    end
    if ((f1.ld_ram_in && f1.ld_ram_out) || (f1.ld_bus_oe != f1.ld_ram_in) ||
        (f0.ld_ram_in && f0.ld_ram_out) || (f0.ld_bus_oe != f0.ld_ram_in)) viol++;
    if (f0.ld_ram_out) ro0++;
  end
  task automatic start(input int w);
    if (w != 0) begin exp_addr = 0; f1.load_start = 1'b1; end
    else begin exp0 = 0; f0.load_start = 1'b1; end
    @(negedge clk);
    f1.load_start = 1'b0;
    f0.load_start = 1'b0;
  endtask
  task automatic send(input int w, input logic [7:0] b, input int gap);
    int t = 0;
    repeat (gap) @(negedge clk);
    if (w != 0) begin f1.in_data = b; f1.in_valid = 1'b1; end
    else begin f0.in_data = b; f0.in_valid = 1'b1; end
    while (((w != 0) ? f1.in_ready : f0.in_ready) !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("ready_timeout", 32'(t < 40), 1);
    @(negedge clk);
    f1.in_valid = 1'b0;
    f0.in_valid = 1'b0;
  endtask
  task automatic wait_end(input int w, output int cc);
    int t = 0;
    while (((w != 0) ? (f1.load_ok | f1.load_err) : (f0.load_ok | f0.load_err)) !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("end_timeout", 32'(t < 100), 1);
    cc = cyc;
  endtask
  task automatic check_mem(input string tag);
    for (int i = 0; i < 16; i++) chk($sformatf("%s_mem%0d", tag, i), 32'(mem[i]), 32'(img[i]));
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    f1.load_start = 1'b0; f1.in_valid = 1'b0; f1.in_data = 8'h00;
    f0.load_start = 1'b0; f0.in_valid = 1'b0; f0.in_data = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_outs1", 32'({f1.in_ready, f1.ld_add, f1.ld_bus_out, f1.ld_bus_oe, f1.ld_ram_in,
                          f1.ld_ram_out, f1.cpu_hold, f1.load_ok, f1.load_err}), 0);
    chk("rst_outs0", 32'({f0.in_ready, f0.ld_add, f0.ld_bus_out, f0.ld_bus_oe, f0.ld_ram_in,
                          f0.ld_ram_out, f0.cpu_hold, f0.load_ok, f0.load_err}), 0);
    chk("rst_state", 32'(u1.state_q), 32'(S_IDLE));
    chk("rst_sum", 32'(u1.wr_sum), 0);
    rst = 1'b0;
    // back-to-back 0x00..0x0F
    for (int i = 0; i < 16; i++) img[i] = 8'(i);
    strobes = 0;
    start(1);
    chk("b2b_hold_wait", 32'(f1.cpu_hold), 1);
    for (int i = 0; i < 16; i++) send(1, img[i], 0);
    chk("b2b_wr_sum", 32'(u1.wr_sum), 32'h78);
    chk("b2b_hold_busy", 32'(f1.cpu_hold), 1);
    wait_end(1, c);
    chk("b2b_latency", 32'(c - w1), 18);
    chk("b2b_ok", 32'(f1.load_ok), 1);
    chk("b2b_err", 32'(f1.load_err), 0);
    chk("b2b_hold_done", 32'(f1.cpu_hold), 0);
    chk("b2b_strobes", 32'(strobes), 16);
    check_mem("b2b");
    // throttled random image
    for (int i = 0; i < 16; i++) img[i] = 8'($urandom_range(0, 255));
    strobes = 0;
    start(1);
    for (int i = 0; i < 16; i++) send(1, img[i], int'($urandom_range(0, 3)));
    wait_end(1, c);
    chk("thr_ok", 32'(f1.load_ok), 1);
    chk("thr_strobes", 32'(strobes), 16);
    check_mem("thr");
    // corrupted readback, then a clean reload
    for (int i = 0; i < 16; i++) img[i] = 8'hA0 + 8'(i);
    corrupt = 1'b1;
    start(1);
    for (int i = 0; i < 16; i++) send(1, img[i], 0);
    wait_end(1, c);
    chk("bad_err", 32'(f1.load_err), 1);
    chk("bad_ok", 32'(f1.load_ok), 0);
    chk("bad_hold", 32'(f1.cpu_hold), 1);
    corrupt = 1'b0;
    start(1);
    chk("bad_err_clr", 32'(f1.load_err), 0);
    for (int i = 0; i < 16; i++) send(1, img[i], 1);
    wait_end(1, c);
    chk("reload_ok", 32'(f1.load_ok), 1);
    chk("reload_err", 32'(f1.load_err), 0);
    // reset after 5 bytes
    for (int i = 0; i < 16; i++) img[i] = 8'h50 + 8'(i);
    strobes = 0;
    start(1);
    for (int i = 0; i < 5; i++) send(1, img[i], 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_state", 32'(u1.state_q), 32'(S_IDLE));
    chk("mid_rst_outs", 32'({f1.in_ready, f1.ld_add, f1.ld_bus_out, f1.ld_bus_oe, f1.ld_ram_in,
                             f1.ld_ram_out, f1.cpu_hold, f1.load_ok, f1.load_err}), 0);
    repeat (3) @(negedge clk);
    chk("mid_rst_strobes", 32'(strobes), 5);
    // restart from address 0, with ignored load_start in WAIT_BYTE and VERIFY
    start(1);
    for (int i = 0; i < 3; i++) send(1, img[i], 0);
    @(negedge clk);
    f1.load_start = 1'b1;
    @(negedge clk);
    f1.load_start = 1'b0;
    chk("ign_wait_state", 32'(u1.state_q), 32'(S_WAIT_BYTE));
    chk("ign_wait_cnt", 32'(u1.cnt_q), 3);
    for (int i = 3; i < 16; i++) send(1, img[i], 0);
    repeat (3) @(negedge clk);
    chk("ign_ver_state", 32'(u1.state_q), 32'(S_VERIFY));
    f1.load_start = 1'b1;
    @(negedge clk);
    f1.load_start = 1'b0;
    wait_end(1, c);
    chk("ign_latency", 32'(c - w1), 18);
    chk("ign_ok", 32'(f1.load_ok), 1);
    check_mem("ign");
    // no-verify instance
    start(0);
    for (int i = 0; i < 16; i++) send(0, 8'(i * 7), 0);
    wait_end(0, c);
    chk("nv_latency", 32'(c - w0), 1);
    chk("nv_ok", 32'(f0.load_ok), 1);
    chk("nv_hold", 32'(f0.cpu_hold), 0);
    chk("nv_ram_out", 32'(ro0), 0);
    chk("strobe_rules", 32'(viol), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
